route_allocator: RTL and testbench
==================================

ROUTE_ALLOCATOR -- requirements
Module: route_allocator

Interface
REQ-001 SHALL have parameter NUM_BUFFERS, default 5, number of input buffers (legal range 2..16).
REQ-002 SHALL have parameter NUM_OUTPORTS, default 5, number of switch output ports (legal range 2..16).
REQ-003 SHALL have parameter TABLE_DEPTH, default 8, number of routing-table entries.
REQ-004 SHALL have parameter DEFAULT_PORT, default 0, output port used on a table miss.
REQ-005 SHALL have these ports:
- CLK  in  1  clock; single clock domain, rising edge
- RST  in  1  synchronous reset, active-high
- in_valid  in  NUM_BUFFERS  buffer holds a flit at its head
- in_head  in  NUM_BUFFERS  head flit is a packet header
- in_last  in  NUM_BUFFERS  head flit is the packet tail
- in_dest  in  NUM_BUFFERS x node_id_t  destination of each head flit
- flit_fire  in  NUM_BUFFERS  head flit consumed through crossbar this cycle
- cfg_we  in  1  routing-table write strobe
- cfg_idx  in  clog2(TABLE_DEPTH)  entry index
- cfg_dest  in  node_id_t  entry destination
- cfg_port  in  clog2(NUM_OUTPORTS)  entry output port
- cfg_valid  in  1  entry valid bit written
- out_sel  out  NUM_OUTPORTS x clog2(NUM_BUFFERS)  buffer driving each output port
- out_busy  out  NUM_OUTPORTS  output port allocated
- allocate  out  NUM_BUFFERS  one-cycle pulse: buffer granted a port
- route_miss  out  1  sticky: a header missed the table

Function
REQ-006 SHALL look up each buffer's in_dest combinationally; lowest-index valid entry with matching dest wins; no match selects DEFAULT_PORT and sets route_miss at next edge.
REQ-007 A buffer SHALL request its looked-up port when in_valid & in_head & buffer unallocated.
REQ-008 Each output port SHALL be a 2-state FSM: IDLE (arbitrate) -> BUSY on grant; BUSY -> IDLE at the edge where the owning buffer asserts flit_fire & in_last.
REQ-009 In IDLE with >=1 requester, port SHALL grant round-robin starting at its pointer; grant registered, so out_busy, out_sel and allocate appear exactly 1 cycle after request.
REQ-010 After grant, port pointer SHALL become (granted index + 1) mod NUM_BUFFERS; pointer unchanged when no grant.
REQ-011 allocate[b] SHALL be high for exactly one cycle per grant; buffer b SHALL stay allocated (no new request) until its tail fires.
REQ-012 out_sel SHALL hold its value while BUSY and SHALL hold last value while IDLE.
REQ-013 A released port SHALL spend at least one cycle IDLE before the next grant (one-cycle bubble).
REQ-014 Ports SHALL arbitrate independently; different ports may grant in the same cycle.
REQ-015 flit_fire from a buffer that owns no port SHALL be ignored.
REQ-016 cfg write SHALL take effect at next edge; a lookup in the write cycle SHALL use old table contents.
REQ-017 Single-flit packet (in_head & in_last) SHALL be granted, then release on its fire like any tail.

Reset
REQ-018 On RST high at an edge: all ports IDLE, out_busy=0, out_sel=0, allocate=0, pointers=0, all table valid bits=0, route_miss=0.
REQ-019 RST mid-packet SHALL drop all allocations; no allocate pulse in the cycle after reset deasserts unless requests are present that cycle.

Structure
REQ-020 node_id_t and route-table entry typedef SHALL live in chiplet_types_pkg.
REQ-021 Round-robin arbiter SHALL be one sub-module, rr_arbiter, instantiated once per output port.

Verification
REQ-022 Reset then write entry0 {dest=3,port=2}; buffer1 header dest=3 -> next cycle allocate[1]=1, out_busy[2]=1, out_sel[2]=1.
REQ-023 Buffers 0,2,4 request port 1 back-to-back 1-flit packets -> grant order 0,2,4 with one idle bubble between grants.
REQ-024 Header dest=9 with empty table -> port DEFAULT_PORT granted, route_miss=1 and stays 1 until RST.
REQ-025 Buffer0 -> port 0 and buffer3 -> port 4 same cycle -> both allocate pulses same cycle.
REQ-026 cfg_we rewrites entry0 port 2->3 in the lookup cycle -> grant on port 2; next header grants on port 3.
REQ-027 RST while port 2 BUSY mid-packet -> out_busy=0 next cycle, pending requester re-granted after RST drops.

Source files
------------

// File: rtl/chiplet_types_pkg.sv
// Shared types for the chiplet router.
//   node_id_t      : destination node identifier carried by header flits
//   route_entry_t  : one routing-table entry {valid, dest, port}
//   port_state_e   : output-port allocation state
//   wrap_inc       : modulo-n increment used by round-robin pointers
package chiplet_types_pkg;

  localparam int unsigned NodeIdW    = 8;
  // Wide enough to name any of up to 16 output ports.
  localparam int unsigned PortFieldW = 4;

  typedef logic [NodeIdW-1:0]    node_id_t;
  typedef logic [PortFieldW-1:0] port_field_t;

  typedef struct packed {
    logic        valid;
    node_id_t    dest;
    port_field_t port;
  } route_entry_t;

  typedef enum logic [0:0] {StIdle, StBusy} port_state_e;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req_i starting at ptr_i and
// wrapping around; the first requester found wins.
//   req_i     : request vector
//   ptr_i     : highest-priority index this cycle
//   gnt_o     : some request was granted
//   gnt_idx_o : index of the granted requester
module rr_arbiter #(
  parameter  int unsigned NumReq = 5,
  localparam int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic              gnt_o,
  output logic [IdxW-1:0]   gnt_idx_o
);

  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_o     = 1'b0;
    gnt_idx_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = 32'(ptr_i) + i;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!gnt_o && req_i[idx]) begin
        gnt_o     = 1'b1;
        gnt_idx_o = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/route_allocator.sv
// Route computation and output-port allocation for a wormhole switch.
// Each buffer's head destination is looked up in a small routing table; a
// header on an unallocated buffer requests the resulting output port. Each
// port owns a round-robin arbiter and holds its winner until the tail fires.
//   CLK, RST                 : clock, synchronous active-high reset
//   in_valid/head/last/dest  : per-buffer head-flit status
//   flit_fire                : per-buffer head flit consumed this cycle
//   cfg_*                    : routing-table write port
//   out_sel, out_busy        : per-port owner and allocation status
//   allocate                 : one-cycle pulse per buffer grant
//   route_miss               : sticky table-miss flag
module route_allocator
  import chiplet_types_pkg::*;
#(
  parameter  int unsigned NUM_BUFFERS  = 5,
  parameter  int unsigned NUM_OUTPORTS = 5,
  parameter  int unsigned TABLE_DEPTH  = 8,
  parameter  int unsigned DEFAULT_PORT = 0,
  localparam int unsigned BufIdxW      = $clog2(NUM_BUFFERS),
  localparam int unsigned PortIdxW     = $clog2(NUM_OUTPORTS),
  localparam int unsigned TblIdxW      = $clog2(TABLE_DEPTH)
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic     [NUM_BUFFERS-1:0]            in_valid,
  input  logic     [NUM_BUFFERS-1:0]            in_head,
  input  logic     [NUM_BUFFERS-1:0]            in_last,
  input  node_id_t [NUM_BUFFERS-1:0]            in_dest,
  input  logic     [NUM_BUFFERS-1:0]            flit_fire,
  input  logic                                  cfg_we,
  input  logic     [TblIdxW-1:0]                cfg_idx,
  input  node_id_t                              cfg_dest,
  input  logic     [PortIdxW-1:0]               cfg_port,
  input  logic                                  cfg_valid,
  output logic     [NUM_OUTPORTS-1:0][BufIdxW-1:0] out_sel,
  output logic     [NUM_OUTPORTS-1:0]           out_busy,
  output logic     [NUM_BUFFERS-1:0]            allocate,
  output logic                                  route_miss
);

  route_entry_t             rt_q [TABLE_DEPTH];
  route_entry_t             rt_d [TABLE_DEPTH];
  port_state_e              state_q [NUM_OUTPORTS];
  port_state_e              state_d [NUM_OUTPORTS];
  logic [BufIdxW-1:0]       sel_q [NUM_OUTPORTS];
  logic [BufIdxW-1:0]       sel_d [NUM_OUTPORTS];
  logic [BufIdxW-1:0]       ptr_q [NUM_OUTPORTS];
  logic [BufIdxW-1:0]       ptr_d [NUM_OUTPORTS];
  logic [NUM_BUFFERS-1:0]   alloc_q, alloc_d;
  logic [NUM_BUFFERS-1:0]   allocate_q, allocate_d;
  logic                     route_miss_q, route_miss_d;

  port_field_t              port_lu [NUM_BUFFERS];
  logic [NUM_BUFFERS-1:0]   hit;
  logic [NUM_BUFFERS-1:0]   arb_req [NUM_OUTPORTS];
  logic [NUM_OUTPORTS-1:0]  arb_gnt;
  logic [BufIdxW-1:0]       arb_idx [NUM_OUTPORTS];

  // Lookup reads the registered table, so a same-cycle cfg write is not seen.
  always_comb begin
    for (int unsigned b = 0; b < NUM_BUFFERS; b++) begin
      port_lu[b] = port_field_t'(DEFAULT_PORT);
      hit[b]     = 1'b0;
      for (int unsigned e = 0; e < TABLE_DEPTH; e++) begin
        if (!hit[b] && rt_q[e].valid && (rt_q[e].dest == in_dest[b])) begin
          hit[b]     = 1'b1;
          port_lu[b] = rt_q[e].port;
        end
      end
    end
  end

  // Only idle ports see requests, so a released port always idles one cycle.
  always_comb begin
    for (int unsigned p = 0; p < NUM_OUTPORTS; p++) begin
      arb_req[p] = '0;
      for (int unsigned b = 0; b < NUM_BUFFERS; b++) begin
        arb_req[p][b] = (state_q[p] == StIdle) && in_valid[b] && in_head[b] && !alloc_q[b]
                        && (port_lu[b] == port_field_t'(p));
      end
    end
  end

  for (genvar p = 0; p < NUM_OUTPORTS; p++) begin : g_port
    rr_arbiter #(
      .NumReq (NUM_BUFFERS)
    ) u_arb (
      .req_i     (arb_req[p]),
      .ptr_i     (ptr_q[p]),
      .gnt_o     (arb_gnt[p]),
      .gnt_idx_o (arb_idx[p])
    );
  end

  always_comb begin
    rt_d         = rt_q;
    alloc_d      = alloc_q;
    allocate_d   = '0;
    route_miss_d = route_miss_q | (|(in_valid & in_head & ~hit));
    state_d      = state_q;
    sel_d        = sel_q;
    ptr_d        = ptr_q;
    if (cfg_we) begin
      rt_d[cfg_idx] = '{valid: cfg_valid, dest: cfg_dest, port: port_field_t'(cfg_port)};
    end
    for (int unsigned p = 0; p < NUM_OUTPORTS; p++) begin
      unique case (state_q[p])
        StIdle: begin
          if (arb_gnt[p]) begin
            state_d[p]             = StBusy;
            sel_d[p]               = arb_idx[p];
            ptr_d[p]               = BufIdxW'(wrap_inc(32'(arb_idx[p]), NUM_BUFFERS));
            alloc_d[arb_idx[p]]    = 1'b1;
            allocate_d[arb_idx[p]] = 1'b1;
          end
        end
        StBusy: begin
          // Only the owning buffer's tail can release the port.
          if (flit_fire[sel_q[p]] && in_last[sel_q[p]]) begin
            state_d[p]        = StIdle;
            alloc_d[sel_q[p]] = 1'b0;
          end
        end
        default: state_d[p] = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned e = 0; e < TABLE_DEPTH; e++) rt_q[e] <= '0;
      for (int unsigned p = 0; p < NUM_OUTPORTS; p++) begin
        state_q[p] <= StIdle;
        sel_q[p]   <= '0;
        ptr_q[p]   <= '0;
      end
      alloc_q      <= '0;
      allocate_q   <= '0;
      route_miss_q <= 1'b0;
    end else begin
      rt_q         <= rt_d;
      state_q      <= state_d;
      sel_q        <= sel_d;
      ptr_q        <= ptr_d;
      alloc_q      <= alloc_d;
      allocate_q   <= allocate_d;
      route_miss_q <= route_miss_d;
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_OUTPORTS; p++) begin
      out_busy[p] = (state_q[p] == StBusy);
      out_sel[p]  = sel_q[p];
    end
    allocate   = allocate_q;
    route_miss = route_miss_q;
  end

endmodule

// File: tb/tb_route_allocator.sv
// Directed bench for route_allocator with a grant scoreboard: stimulus
// pushes the expected grant, a negedge monitor pops it whenever allocate
// pulses and compares allocate, out_busy and the relevant out_sel fields.
module tb_route_allocator;
  import chiplet_types_pkg::*;

  localparam int NB = 5;
  localparam int NP = 5;
  localparam int BW = 3;
  localparam int PW = 3;
  localparam int TW = 3;

  logic                   CLK = 1'b0;
  logic                   RST = 1'b1;
  logic     [NB-1:0]      in_valid  = '0;
  logic     [NB-1:0]      in_head   = '0;
  logic     [NB-1:0]      in_last   = '0;
  node_id_t [NB-1:0]      in_dest   = '0;
  logic     [NB-1:0]      flit_fire = '0;
  logic                   cfg_we    = 1'b0;
  logic     [TW-1:0]      cfg_idx   = '0;
  node_id_t               cfg_dest  = '0;
  logic     [PW-1:0]      cfg_port  = '0;
  logic                   cfg_valid = 1'b0;
  logic     [NP-1:0][BW-1:0] out_sel;
  logic     [NP-1:0]      out_busy;
  logic     [NB-1:0]      allocate;
  logic                   route_miss;

  route_allocator #(
    .NUM_BUFFERS  (NB),
    .NUM_OUTPORTS (NP),
    .TABLE_DEPTH  (8),
    .DEFAULT_PORT (0)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_head    (in_head),
    .in_last    (in_last),
    .in_dest    (in_dest),
    .flit_fire  (flit_fire),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_dest   (cfg_dest),
    .cfg_port   (cfg_port),
    .cfg_valid  (cfg_valid),
    .out_sel    (out_sel),
    .out_busy   (out_busy),
    .allocate   (allocate),
    .route_miss (route_miss)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NB-1:0]         alloc;
    logic [NP-1:0]         busy;
    logic [NP-1:0]         sel_mask;
    logic [NP-1:0][BW-1:0] sel;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid  = '0;
    in_head   = '0;
    in_last   = '0;
    flit_fire = '0;
  endtask

  task automatic cfg_write(input int idx, input int dest, input int port);
    cfg_we    = 1'b1;
    cfg_idx   = TW'(idx);
    cfg_dest  = node_id_t'(dest);
    cfg_port  = PW'(port);
    cfg_valid = 1'b1;
    tick();
    cfg_we    = 1'b0;
  endtask

  // pa/pb < 0 means no out_sel field to check.
  task automatic expect_grant(input logic [NB-1:0] alloc, input logic [NP-1:0] busy,
                              input int pa, input int sa, input int pb, input int sb);
    exp_t e;
    e.alloc    = alloc;
    e.busy     = busy;
    e.sel_mask = '0;
    e.sel      = '0;
    if (pa >= 0) begin
      e.sel_mask[pa] = 1'b1;
      e.sel[pa]      = BW'(sa);
    end
    if (pb >= 0) begin
      e.sel_mask[pb] = 1'b1;
      e.sel[pb]      = BW'(sb);
    end
    exp_q.push_back(e);
  endtask

  task automatic release_buf(input int b);
    in_head[b]   = 1'b0;
    in_last[b]   = 1'b1;
    flit_fire[b] = 1'b1;
    tick();
    clear_inputs();
  endtask

  always @(negedge CLK) begin
    if (!RST && allocate != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_allocate", 32'(allocate), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("allocate", 32'(allocate), 32'(mon_e.alloc));
        check("out_busy", 32'(out_busy), 32'(mon_e.busy));
        for (int p = 0; p < NP; p++) begin
          if (mon_e.sel_mask[p]) begin
            check($sformatf("out_sel[%0d]", p), 32'(out_sel[p]), 32'(mon_e.sel[p]));
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    RST = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(out_busy), 32'd0);
    check("rst_sel", 32'(out_sel), 32'd0);
    check("rst_allocate", 32'(allocate), 32'd0);
    check("rst_miss", 32'(route_miss), 32'd0);
    RST = 1'b0;

    // Table hit: dest 3 -> port 2 for buffer 1
    cfg_write(0, 3, 2);
    in_valid[1] = 1'b1;
    in_head[1]  = 1'b1;
    in_dest[1]  = 8'd3;
    expect_grant(5'b00010, 5'b00100, 2, 1, -1, 0);
    tick();
    // Stray tail fire from a non-owner must not release port 2
    in_valid[3]  = 1'b1;
    in_last[3]   = 1'b1;
    flit_fire[3] = 1'b1;
    tick();
    check("t1_stray_fire", 32'(out_busy), 32'b00100);
    clear_inputs();
    in_valid[1] = 1'b1;
    release_buf(1);
    check("t1_release", 32'(out_busy), 32'd0);
    check("t1_sel_hold", 32'(out_sel[2]), 32'd1);
    check("t1_no_miss", 32'(route_miss), 32'd0);

    // Back-to-back single-flit packets from buffers 0,2,4 onto port 1
    cfg_write(1, 5, 1);
    for (int b = 0; b < NB; b += 2) begin
      in_valid[b] = 1'b1;
      in_head[b]  = 1'b1;
      in_last[b]  = 1'b1;
      in_dest[b]  = 8'd5;
    end
    expect_grant(5'b00001, 5'b00010, 1, 0, -1, 0);
    tick();
    flit_fire[0] = 1'b1;
    expect_grant(5'b00100, 5'b00010, 1, 2, -1, 0);
    tick();
    flit_fire[0] = 1'b0;
    in_valid[0]  = 1'b0;
    check("t2_bubble_a", 32'(out_busy[1]), 32'd0);
    tick();
    flit_fire[2] = 1'b1;
    expect_grant(5'b10000, 5'b00010, 1, 4, -1, 0);
    tick();
    flit_fire[2] = 1'b0;
    in_valid[2]  = 1'b0;
    check("t2_bubble_b", 32'(out_busy[1]), 32'd0);
    tick();
    flit_fire[4] = 1'b1;
    tick();
    clear_inputs();
    check("t2_done", 32'(out_busy), 32'd0);

    // Table miss -> DEFAULT_PORT, sticky route_miss
    check("t3_miss_before", 32'(route_miss), 32'd0);
    in_valid[3] = 1'b1;
    in_head[3]  = 1'b1;
    in_dest[3]  = 8'd9;
    expect_grant(5'b01000, 5'b00001, 0, 3, -1, 0);
    tick();
    check("t3_miss_set", 32'(route_miss), 32'd1);
    release_buf(3);
    tick();
    check("t3_miss_sticky", 32'(route_miss), 32'd1);
    check("t3_done", 32'(out_busy), 32'd0);

    // Independent ports grant in the same cycle
    cfg_write(2, 7, 4);
    in_valid[0] = 1'b1;
    in_head[0]  = 1'b1;
    in_dest[0]  = 8'd9;
    in_valid[3] = 1'b1;
    in_head[3]  = 1'b1;
    in_dest[3]  = 8'd7;
    expect_grant(5'b01001, 5'b10001, 0, 0, 4, 3);
    tick();
    in_head      = '0;
    in_last      = 5'b01001;
    flit_fire    = 5'b01001;
    tick();
    clear_inputs();
    check("t4_done", 32'(out_busy), 32'd0);

    // cfg rewrite in the lookup cycle: old route used, new route next time
    in_valid[1] = 1'b1;
    in_head[1]  = 1'b1;
    in_dest[1]  = 8'd3;
    cfg_we      = 1'b1;
    cfg_idx     = 3'd0;
    cfg_dest    = 8'd3;
    cfg_port    = 3'd3;
    cfg_valid   = 1'b1;
    expect_grant(5'b00010, 5'b00100, 2, 1, -1, 0);
    tick();
    cfg_we = 1'b0;
    release_buf(1);
    in_valid[2] = 1'b1;
    in_head[2]  = 1'b1;
    in_dest[2]  = 8'd3;
    expect_grant(5'b00100, 5'b01000, 3, 2, -1, 0);
    tick();
    release_buf(2);
    check("t5_done", 32'(out_busy), 32'd0);

    // Reset mid-packet with a pending requester
    cfg_write(3, 11, 2);
    in_valid[4] = 1'b1;
    in_head[4]  = 1'b1;
    in_dest[4]  = 8'd11;
    in_valid[0] = 1'b1;
    in_head[0]  = 1'b1;
    in_dest[0]  = 8'd11;
    expect_grant(5'b10000, 5'b00100, 2, 4, -1, 0);
    tick();
    in_head[4] = 1'b0;
    tick();
    check("t6_busy_pre_rst", 32'(out_busy), 32'b00100);
    RST         = 1'b1;
    in_valid[4] = 1'b0;
    tick();
    check("t6_rst_busy", 32'(out_busy), 32'd0);
    check("t6_rst_allocate", 32'(allocate), 32'd0);
    check("t6_rst_miss", 32'(route_miss), 32'd0);
    RST = 1'b0;
    // Table was cleared, so buffer 0 now misses and goes to port 0.
    expect_grant(5'b00001, 5'b00001, 0, 0, -1, 0);
    tick();
    check("t6_miss_again", 32'(route_miss), 32'd1);
    release_buf(0);
    tick();
    tick();
    check("t6_done", 32'(out_busy), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
